alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//  Execute stage of the RISC datapath. Sits between the register-read stage and
//  the ALU32 result consumers (writeback/branch logic).
//  Accepts one operation per handshake, computes single-cycle ALU ops including
//  SLT/SGT compare, and runs SLL/SRL/SRA as a 1-bit-per-cycle iterative shifter.
//  Holds the registered result until the consumer accepts it.
// PARAMETERS
//  N    32  datapath width in bits
//  SHW   5  shift-amount width; N must equal 2**SHW
// PORTS
//  clk        in   1    single clock; all state updates on rising edge
//  rst        in   1    synchronous, active-high reset
//  in_valid   in   1    upstream presents op/a/b
//  in_ready   out  1    stage can accept; high only in IDLE
//  op         in   4    0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SLT, 7 SGT,
//                       8 SLL, 9 SRL, 10 SRA, 11-15 reserved
//  a          in   N    operand A
//  b          in   N    operand B; b[SHW-1:0] is the shift amount for ops 8-10
//  out_valid  out  1    result register holds a completed result
//  out_ready  in   1    downstream accepts result
//  result     out  N    registered result
//  zero       out  1    result == 0, combinational from the result register
//  busy       out  1    high in SHIFT state
// BEHAVIOUR
//  Reset (rst high at an edge): state IDLE, result 0, out_valid 0, shift counter 0.
//   After reset: in_ready 1, zero 1, busy 0. Reset overrides all other inputs.
//  FSM states IDLE, SHIFT, DONE:
//   IDLE : in_ready=1. Accept on in_valid & in_ready.
//          Non-shift op, or shift with amount 0 -> load result; next state DONE.
//          Shift with amount s>0 -> load work reg with a, count=s; next state SHIFT.
//   SHIFT: one 1-bit shift per cycle, count decrements.
//          Transition to DONE on the edge where count goes 1->0.
//          in_ready=0; in_valid is ignored.
//   DONE : out_valid=1; result and zero stay stable.
//          On out_ready go to IDLE, with out_valid low the next cycle.
//          in_ready=0; no overlap of accept and drain.
//  Latency: out_valid rises 1 cycle after accept for single-cycle ops;
//   s+1 cycles after accept for a shift by s>0. Throughput is at most 1 op per 2 cycles.
//  Arithmetic:
//   ADD/SUB: modulo 2**N; no carry or overflow outputs.
//   SLT: result = {N-1 zeros, bit N-1 of (a-b) mod 2**N}.
//   SGT: result = {N-1 zeros, bit N-1 of (b-a) mod 2**N}.
//   Both compares use raw sign bits with no overflow correction, matching ALU32.
//   SLL/SRL shift in zeros. SRA replicates a[N-1].
//   Upper bits of b above SHW are ignored for shifts.
//  Reserved op: result 0, single-cycle latency.
//  Reset mid-SHIFT or mid-DONE: operation dropped; no out_valid is produced.
//  out_ready is ignored outside DONE. in_valid is ignored outside IDLE; upstream must hold it.
// TESTING
//  T1 reset: rst=1 for 2 cycles -> out_valid=0, in_ready=1, result=0, zero=1, busy=0.
//  T2 SGT (op 7): a=5,b=3 -> result=1, out_valid 1 cycle after accept;
//     a=3,b=5 -> result=0, zero=1; a=b=7 -> result=0.
//  T3 SLL (op 8): a=0x00000001, b=4 -> busy for 4 cycles, out_valid 5 cycles after
//     accept, result=0x00000010; SLL with b=0 -> result=a after 1 cycle.
//  T4 SRA (op 10): a=0x80000000, b=31 -> result=0xFFFFFFFF;
//     b=0x25 (amount 5) -> result=0xFC000000; SRL same a, b=31 -> result=0x00000001.
//  T5 backpressure: ADD 0xFFFFFFFF+1 with out_ready=0 for 3 cycles -> result=0, zero=1,
//     held stable; in_ready=0, and an in_valid pulse meanwhile is not accepted.
//  T6 reset in SHIFT: SLL by 20, assert rst on the 3rd SHIFT cycle -> next cycle
//     IDLE, out_valid=0, result=0; a following ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle ALU ops plus a 1-bit-per-cycle iterative shifter,
// with a valid/ready handshake on both sides and a held result register.
//
// state | meaning
// IDLE  | in_ready high, waiting to accept an operation
// SHIFT | iterating a shift, one bit per cycle, busy high
// DONE  | result register valid, waiting for out_ready
module alu_exec_stage #(
  parameter int N   = 32,
  parameter int SHW = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_SGT = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRL = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;

  state_t         r_state;
  logic [N-1:0]   r_result;
  logic [N-1:0]   r_work;
  logic [SHW-1:0] r_count;
  logic [1:0]     r_kind;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_busy;

  logic           w_swap;
  logic [N-1:0]   w_sub_x;
  logic [N-1:0]   w_sub_y;
  logic [N-1:0]   w_diff;
  logic [N-1:0]   w_alu;
  logic [N-1:0]   w_shift_next;
  logic           w_is_shift;
  logic           w_accept;

  // SLT and SGT share the SUB subtractor; SGT just swaps the operands.
  assign w_swap  = (op == OP_SGT);
  assign w_sub_x = w_swap ? b : a;
  assign w_sub_y = w_swap ? a : b;
  assign w_diff  = w_sub_x - w_sub_y;

  assign w_is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  assign w_accept   = in_valid && r_in_ready;

  always_comb begin
    w_alu = '0;
    case (op)
      OP_ADD:                 w_alu = a + b;
      OP_SUB:                 w_alu = w_diff;
      OP_AND:                 w_alu = a & b;
      OP_OR:                  w_alu = a | b;
      OP_XOR:                 w_alu = a ^ b;
      OP_NOT:                 w_alu = ~a;
      OP_SLT, OP_SGT:         w_alu = {{(N-1){1'b0}}, w_diff[N-1]};
      OP_SLL, OP_SRL, OP_SRA: w_alu = a;
      default:                w_alu = '0;
    endcase
  end

  // r_kind: 0 SLL, 1 SRL, 2 SRA (low bits of the opcode)
  always_comb begin
    w_shift_next = r_work;
    case (r_kind)
      2'd0:    w_shift_next = {r_work[N-2:0], 1'b0};
      2'd1:    w_shift_next = {1'b0, r_work[N-1:1]};
      default: w_shift_next = {r_work[N-1], r_work[N-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_result    <= '0;
      r_work      <= '0;
      r_count     <= '0;
      r_kind      <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (w_is_shift && (b[SHW-1:0] != '0)) begin
              r_work  <= a;
              r_count <= b[SHW-1:0];
              r_kind  <= op[1:0];
              r_busy  <= 1'b1;
              r_state <= S_SHIFT;
            end else begin
              r_result    <= w_alu;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          r_work  <= w_shift_next;
          r_count <= r_count - 1'b1;
          if (r_count == SHW'(1)) begin
            r_result    <= w_shift_next;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign result    = r_result;
  assign zero      = (r_result == '0);

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed cases then random ops checked against
// an arithmetic reference model of the ALU and its latency.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  alu_exec_stage #(.N(32), .SHW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] mop, input logic [31:0] ma,
                                        input logic [31:0] mb);
    logic [31:0]        d;
    logic signed [31:0] sa;
    int                 s;
    s  = int'(mb % 32);
    sa = ma;
    case (mop)
      4'd0:  return ma + mb;
      4'd1:  return ma - mb;
      4'd2:  return ma & mb;
      4'd3:  return ma | mb;
      4'd4:  return ma ^ mb;
      4'd5:  return ~ma;
      4'd6:  begin d = ma - mb; return {31'd0, d[31]}; end
      4'd7:  begin d = mb - ma; return {31'd0, d[31]}; end
      4'd8:  return ma << s;
      4'd9:  return ma >> s;
      4'd10: return 32'(sa >>> s);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] mop, input logic [31:0] mb);
    if (mop >= 4'd8 && mop <= 4'd10 && (mb % 32) != 0) return int'(mb % 32) + 1;
    return 1;
  endfunction

  // Starts and ends on a falling edge. hold = cycles out_ready stays low in DONE;
  // poke drives a stray in_valid pulse while the result is being held.
  task automatic do_op(input string tag, input logic [3:0] top, input logic [31:0] ta,
                       input logic [31:0] tb, input int hold, input bit poke);
    logic [31:0] exp_r;
    int          exp_lat;
    int          lat;
    int          busy_cnt;
    exp_r   = model(top, ta, tb);
    exp_lat = model_lat(top, tb);
    check({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op = top;
    a  = ta;
    b  = tb;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = 1;
    busy_cnt = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    check({tag, " result"}, result, exp_r);
    check({tag, " zero"}, 32'(zero), 32'(exp_r == 32'd0));
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 0) begin
        in_valid = 1'b1;
        op = 4'd0;
        a  = 32'd1;
        b  = 32'd1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, " held_result"}, result, exp_r);
      check({tag, " held_valid"}, 32'(out_valid), 32'd1);
      check({tag, " held_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " drained_valid"}, 32'(out_valid), 32'd0);
    check({tag, " drained_in_ready"}, 32'(in_ready), 32'd1);
    if (poke) begin
      repeat (2) @(negedge clk);
      check({tag, " poke_not_taken"}, 32'(out_valid), 32'd0);
      check({tag, " poke_result"}, result, exp_r);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 4'd0;
    a         = 32'd0;
    b         = 32'd0;

    // T1 reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset result", result, 32'd0);
    check("reset zero", 32'(zero), 32'd1);
    check("reset busy", 32'(busy), 32'd0);

    // T2 SGT
    do_op("sgt_5_3", 4'd7, 32'd5, 32'd3, 0, 1'b0);
    do_op("sgt_3_5", 4'd7, 32'd3, 32'd5, 0, 1'b0);
    do_op("sgt_7_7", 4'd7, 32'd7, 32'd7, 0, 1'b0);
    do_op("slt_3_5", 4'd6, 32'd3, 32'd5, 0, 1'b0);

    // T3 SLL
    do_op("sll_1_4", 4'd8, 32'h0000_0001, 32'd4, 0, 1'b0);
    do_op("sll_b0", 4'd8, 32'hDEAD_BEEF, 32'd0, 0, 1'b0);

    // T4 SRA / SRL
    do_op("sra_31", 4'd10, 32'h8000_0000, 32'd31, 0, 1'b0);
    do_op("sra_0x25", 4'd10, 32'h8000_0000, 32'h25, 0, 1'b0);
    do_op("srl_31", 4'd9, 32'h8000_0000, 32'd31, 0, 1'b0);

    // T5 backpressure with a stray in_valid pulse
    do_op("add_wrap_bp", 4'd0, 32'hFFFF_FFFF, 32'd1, 3, 1'b1);
    do_op("reserved_13", 4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 1, 1'b0);
    do_op("xor_nonzero", 4'd4, 32'hA5A5_0000, 32'h0000_5A5A, 0, 1'b0);

    // T6 reset on the third SHIFT cycle
    in_valid = 1'b1;
    op = 4'd8;
    a  = 32'h0000_0003;
    b  = 32'd20;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("t6 busy_after_accept", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6 in_ready", 32'(in_ready), 32'd1);
    check("t6 out_valid", 32'(out_valid), 32'd0);
    check("t6 result", result, 32'd0);
    check("t6 busy", 32'(busy), 32'd0);
    repeat (25) @(negedge clk);
    check("t6 no_late_valid", 32'(out_valid), 32'd0);
    do_op("t6 add_2_3", 4'd0, 32'd2, 32'd3, 0, 1'b0);

    // Random ops
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if ((i % 4) == 0) rb = ra;
      do_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb,
            int'($urandom_range(0, 2)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
